// File: rtl/chroni_bitmap_expander.sv
// Expands one bitmap byte into up to eight colour-index writes to a line buffer,
// one pixel per clock, MSB first, with addresses wrapping at LINE_SIZE.
module chroni_bitmap_expander #(
    parameter int ADDR_W    = 11,
    parameter int LINE_SIZE = 1280
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [7:0]        wr_bitmap_on,
    input  logic [7:0]        wr_bitmap_off,
    input  logic [3:0]        wr_bitmap_bits,
    output logic              wr_busy,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_data,
    output logic              overrun
);

    typedef enum logic {IDLE, EXPAND} state_t;

    localparam logic [ADDR_W:0] LINE_W = (ADDR_W+1)'(LINE_SIZE);

    state_t            state_q, state_d;
    logic [7:0]        data_q, data_d, on_q, on_d, off_q, off_d;
    logic [3:0]        cnt_q, cnt_d, idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              buf_we_q, buf_we_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [7:0]        buf_data_q, buf_data_d;
    logic              overrun_q, overrun_d;

    logic              accept;
    logic [3:0]        bits_clamped;
    logic [3:0]        nxt_idx;
    logic [ADDR_W-1:0] addr_in_mod;
    logic [ADDR_W:0]   addr_sum;

    assign accept       = wr_en && (state_q == IDLE);
    assign bits_clamped = (wr_bitmap_bits > 4'd8) ? 4'd8 : wr_bitmap_bits;
    assign nxt_idx      = idx_q + 4'd1;
    // One subtraction is enough: LINE_SIZE covers more than half the address space.
    assign addr_in_mod  = ({1'b0, wr_addr} >= LINE_W) ? (wr_addr - LINE_W[ADDR_W-1:0]) : wr_addr;
    assign addr_sum     = {1'b0, addr_q} + {{(ADDR_W-3){1'b0}}, nxt_idx};

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            data_q     <= '0;
            on_q       <= '0;
            off_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            addr_q     <= '0;
            buf_we_q   <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            on_q       <= on_d;
            off_q      <= off_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            buf_we_q   <= buf_we_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (wr_en && (bits_clamped != 4'd0)) state_d = EXPAND;
            EXPAND:  if (nxt_idx >= cnt_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pixel 0 is registered straight from the ports on the acceptance edge so
    // the write stream lines up exactly with the EXPAND state.
    always_comb begin
        data_d     = data_q;
        on_d       = on_q;
        off_d      = off_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        buf_we_d   = 1'b0;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        overrun_d  = overrun_q | (wr_en && (state_q == EXPAND));
        if (accept) begin
            data_d = wr_data;
            on_d   = wr_bitmap_on;
            off_d  = wr_bitmap_off;
            cnt_d  = bits_clamped;
            idx_d  = 4'd0;
            addr_d = addr_in_mod;
            if (bits_clamped != 4'd0) begin
                buf_we_d   = 1'b1;
                buf_addr_d = addr_in_mod;
                buf_data_d = wr_data[7] ? wr_bitmap_on : wr_bitmap_off;
            end
        end else if ((state_q == EXPAND) && (nxt_idx < cnt_q)) begin
            idx_d      = nxt_idx;
            buf_we_d   = 1'b1;
            buf_addr_d = (addr_sum >= LINE_W) ? (addr_sum[ADDR_W-1:0] - LINE_W[ADDR_W-1:0])
                                              : addr_sum[ADDR_W-1:0];
            buf_data_d = data_q[3'(4'd7 - nxt_idx)] ? on_q : off_q;
        end
    end

    assign wr_busy  = (state_q == EXPAND);
    assign buf_we   = buf_we_q;
    assign buf_addr = buf_addr_q;
    assign buf_data = buf_data_q;
    assign overrun  = overrun_q;

endmodule

// File: doc/chroni_bitmap_expander.md
CHRONI_BITMAP_EXPANDER -- requirements
Module: chroni_bitmap_expander

Interface
REQ-001 Parameter: ADDR_W, default 11, line-buffer address width.
REQ-002 Parameter: LINE_SIZE, default 1280, line-buffer depth in pixels (two 640-pixel halves).
REQ-003 Port: sys_clk  input  1  the block's single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: wr_en  input  1  command strobe, sampled each cycle.
REQ-006 Port: wr_addr  input  ADDR_W  line-buffer address of the command's first pixel.
REQ-007 Port: wr_data  input  8  bitmap byte, MSB is the leftmost pixel.
REQ-008 Port: wr_bitmap_on  input  8  colour index for set bits.
REQ-009 Port: wr_bitmap_off  input  8  colour index for clear bits.
REQ-010 Port: wr_bitmap_bits  input  4  pixel count, 0-8; values 9-15 clamp to 8.
REQ-011 Port: wr_busy  output  1  high while a command is expanding.
REQ-012 Port: buf_we  output  1  line-buffer write enable.
REQ-013 Port: buf_addr  output  ADDR_W  line-buffer write address.
REQ-014 Port: buf_data  output  8  line-buffer write data (colour index).
REQ-015 Port: overrun  output  1  sticky flag: a command was dropped.

Function
REQ-016 States: IDLE and EXPAND only; reset and power-up enter IDLE.
REQ-017 Acceptance: a command is accepted at a rising edge where wr_en=1 and state=IDLE.
REQ-018 Capture: on acceptance, latch wr_data, on, off, clamped bit count and wr_addr into internal registers.
REQ-019 Transition: on acceptance with count>0, go to EXPAND.
REQ-020 Zero count: on acceptance with count=0, stay in IDLE, produce no writes and leave wr_busy low.
REQ-021 Output registering: wr_busy = (state==EXPAND), registered; it rises the cycle after acceptance.
REQ-022 Write rate: in EXPAND, buf_we=1 every cycle, one pixel per cycle.
REQ-023 Pixel order: pixel i (i=0..k-1) is written in cycle N+1+i, where N is the acceptance edge.
REQ-024 Pixel data: pixel i has buf_data = bit(7-i) of the latched byte ? on : off.
REQ-025 Pixel address: buf_addr = latched address + i, modulo LINE_SIZE.
REQ-026 Address wrap: address LINE_SIZE-1 is followed by 0 within a single command.
REQ-027 Completion: after the k-th write, return to IDLE; wr_busy and buf_we are low in cycle N+k+1.
REQ-028 Back-to-back: a new command may be accepted at edge N+k+1, so the minimum command period is k+1 cycles.
REQ-029 Drop rule: wr_en=1 while state=EXPAND is ignored.
REQ-030 Overrun: a dropped command sets overrun=1, which stays set until reset.
REQ-031 Stable latches: latched fields do not change during EXPAND, regardless of the input ports.
REQ-032 Quiet outputs: in IDLE, buf_we=0; buf_addr and buf_data hold their last values.
REQ-033 Write merge: a command overlaps its final write with nothing; exactly k writes occur per accepted command.

Reset
REQ-034 Reset values: while reset=1 at an edge: state=IDLE, wr_busy=0, buf_we=0, buf_addr=0, buf_data=0, overrun=0, internal counters=0.
REQ-035 Reset abort: reset during EXPAND aborts the command immediately; no further buf_we pulse occurs after the reset edge.
REQ-036 Reset priority: a wr_en in the same cycle as reset is discarded.

Verification
REQ-037 Single command: wr_en with addr=16, data=0xA5, on=0x0F, off=0x01, bits=8 -> writes at 16..23 of 0F,01,0F,01,01,0F,01,0F in cycles N+1..N+8; wr_busy high for exactly 8 cycles.
REQ-038 Partial and clamped counts: bits=3 with data=0xC0 -> 3 writes (on,on,off), busy for 3 cycles; bits=12 -> exactly 8 writes.
REQ-039 Wrap and zero count: addr=1278, bits=4 -> writes at addresses 1278, 1279, 0, 1; bits=0 -> no buf_we, wr_busy stays 0.
REQ-040 Back-to-back and overrun: a second wr_en issued 2 cycles after the first is dropped and overrun=1; a command issued at N+9 after an 8-bit command is accepted with no gap beyond one idle cycle.
REQ-041 Reset mid-command: reset asserted in cycle N+3 -> buf_we=0 from the next edge; wr_busy=0 and overrun=0; a new command afterwards expands normally.
REQ-042 Checking: the bench's scoreboard models the line buffer and compares all 1280 entries after a randomized 80-command line.
